// File: rtl/systolic_feeder.sv
// Holds two 4x4 operand matrices and replays them as a diagonally skewed
// stream (rows west, columns north) for a 4x4 output-stationary systolic array.
module systolic_feeder #(
    parameter int WIDTH      = 16,
    parameter int FRAC_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] out_north0,
    output logic [WIDTH-1:0] out_north1,
    output logic [WIDTH-1:0] out_north2,
    output logic [WIDTH-1:0] out_north3,
    output logic [WIDTH-1:0] out_west0,
    output logic [WIDTH-1:0] out_west4,
    output logic [WIDTH-1:0] out_west8,
    output logic [WIDTH-1:0] out_west12,
    output logic             out_valid,
    output logic             done
);

    // Data is opaque fixed point here; only reject a nonsensical format.
    if (FRAC_WIDTH > WIDTH) begin : g_bad_frac_width
        $error("FRAC_WIDTH must not exceed WIDTH");
    end

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    localparam logic [2:0] LAST_STEP = 3'd6;

    state_t           state_reg, state_next;
    logic [2:0]       t_reg, t_next;
    logic [WIDTH-1:0] a_reg [16];
    logic [WIDTH-1:0] b_reg [16];
    logic [WIDTH-1:0] a_eff [16];
    logic [WIDTH-1:0] b_eff [16];
    logic [WIDTH-1:0] west_reg  [4];
    logic [WIDTH-1:0] north_reg [4];
    logic [WIDTH-1:0] west_next [4];
    logic [WIDTH-1:0] north_next[4];
    logic             wr_commit;
    logic             load_step;
    logic [2:0]       step_sel;

    assign wr_commit = wr_en && (state_reg == IDLE);

    // a_eff/b_eff forward a same-edge write so a start on that edge streams it.
    for (genvar gi = 0; gi < 16; gi++) begin : g_fwd
        assign a_eff[gi] = (wr_commit && !wr_sel && wr_addr == 4'(gi)) ? wr_data : a_reg[gi];
        assign b_eff[gi] = (wr_commit &&  wr_sel && wr_addr == 4'(gi)) ? wr_data : b_reg[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                a_reg[i] <= a_eff[i];
                b_reg[i] <= b_eff[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            t_reg     <= '0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                    t_next     = '0;
                end
            end
            STREAM: begin
                if (t_reg == LAST_STEP) begin
                    state_next = DONE;
                    t_next     = '0;
                end else begin
                    t_next = t_reg + 3'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_ready  = (state_reg == IDLE);
        busy      = (state_reg == STREAM) || (state_reg == DONE);
        out_valid = (state_reg == STREAM);
        done      = (state_reg == DONE);
        load_step = ((state_reg == IDLE) && start) ||
                    ((state_reg == STREAM) && (t_reg != LAST_STEP));
        step_sel  = (state_reg == IDLE) ? 3'd0 : t_reg + 3'd1;
    end

    // Lane gi is delayed gi steps; a 3-bit difference above 3 means "outside window".
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [2:0] dly;
        assign dly            = step_sel - 3'(gi);
        assign west_next[gi]  = (load_step && dly <= 3'd3) ?
                                a_eff[{2'(gi), 2'd3 - dly[1:0]}] : '0;
        assign north_next[gi] = (load_step && dly <= 3'd3) ?
                                b_eff[{2'd3 - dly[1:0], 2'(gi)}] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                west_reg[i]  <= '0;
                north_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                west_reg[i]  <= west_next[i];
                north_reg[i] <= north_next[i];
            end
        end
    end

    assign out_west0  = west_reg[0];
    assign out_west4  = west_reg[1];
    assign out_west8  = west_reg[2];
    assign out_west12 = west_reg[3];
    assign out_north0 = north_reg[0];
    assign out_north1 = north_reg[1];
    assign out_north2 = north_reg[2];
    assign out_north3 = north_reg[3];

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width; Q(WIDTH-FRAC_WIDTH).FRAC_WIDTH fixed point.
REQ-002 SHALL have parameter FRAC_WIDTH, default 8: fractional bits; pass-through only, no arithmetic here.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port wr_en, input, 1 bit: matrix element write request.
REQ-006 SHALL have port wr_sel, input, 1 bit: write target; 0 = matrix A (west operand), 1 = matrix B (north operand).
REQ-007 SHALL have port wr_addr, input, 4 bits: element index, row*4+col.
REQ-008 SHALL have port wr_data, input, WIDTH bits: element value.
REQ-009 SHALL have port wr_ready, output, 1 bit: writes accepted this cycle.
REQ-010 SHALL have port start, input, 1 bit: begin skewed stream of stored A and B.
REQ-011 SHALL have port busy, output, 1 bit: stream or done phase in progress.
REQ-012 SHALL have ports out_north0..out_north3, output, WIDTH bits each: feed for systolic_array in_north0..in_north3.
REQ-013 SHALL have ports out_west0, out_west4, out_west8, out_west12, output, WIDTH bits each: feed for systolic_array in_west0/4/8/12.
REQ-014 SHALL have port out_valid, output, 1 bit: high while stream step values are driven.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse after last stream step.

Function
REQ-016 SHALL store two 4x4 matrices of WIDTH-bit registers, A and B.
REQ-017 SHALL implement FSM states IDLE, STREAM, DONE; reset state IDLE.
REQ-018 SHALL drive wr_ready=1 only in IDLE; busy=1 in STREAM and DONE.
REQ-019 SHALL commit wr_data to A[wr_addr] (wr_sel=0) or B[wr_addr] (wr_sel=1) on an edge where wr_en=1 and wr_ready=1; wr_en outside IDLE is ignored, storage unchanged.
REQ-020 SHALL, on an edge in IDLE with start=1, enter STREAM with step counter t=0; start in STREAM/DONE is ignored.
REQ-021 SHALL, when wr_en and start are both high in IDLE, commit the write on that edge and include the written value in the stream.
REQ-022 SHALL register all data outputs; step t values appear after edge k+t, where k is the start edge, t = 0..6.
REQ-023 SHALL drive out_west(4i) = A[i][3-(t-i)] when 0 <= t-i <= 3, else 0, for row i = 0..3.
REQ-024 SHALL drive out_north(j) = B[3-(t-j)][j] when 0 <= t-j <= 3, else 0, for column j = 0..3.
REQ-025 SHALL hold out_valid=1 for exactly the 7 stream steps.
REQ-026 SHALL, after step 6, enter DONE for one cycle: all data outputs 0, out_valid=0, done=1; then return to IDLE.
REQ-027 SHALL drive all data outputs 0 and out_valid=0 in IDLE.
REQ-028 SHALL keep A and B unchanged by streaming, so the same matrices stream again on repeated start.

Reset
REQ-029 SHALL, while rst=1 (asynchronous, any state, including mid-stream), force IDLE, t=0, all A/B elements 0, all data outputs 0, out_valid=0, done=0, busy=0, wr_ready=1.
REQ-030 SHALL ignore start and wr_en while rst=1; normal operation resumes on the first rising edge after rst falls.

Verification
REQ-031 Load A=[2 1 2 1; 0 1 0 1; 1 2 0 1; 1 1 1 0] and B=[0 1 4 3; 3 0 1 0; 1 4 1 2; 3 0 2 0] (Q8.8); start -> step0: west0=0x0100, north0=0x0300, all other outputs 0; step1: west0=0x0200, west4=0x0100, north0=0x0100, north1=0x0000.
REQ-032 Same load feeding systolic_array -> product [8 10 13 10; 6 0 3 0; 9 1 8 3; 4 5 6 5] (0x0800 etc.); out_valid high exactly 7 cycles; done pulses once at edge k+7; busy low at k+8.
REQ-033 wr_en=1, wr_sel=0, wr_addr=0, wr_data=0x7F00 during STREAM -> wr_ready=0; a second start streams the original A[0][0]=0x0200 at step 3 on west0.
REQ-034 wr_en (B[0][0]=0x0500) and start on the same IDLE edge -> step 3 drives north0=0x0500.
REQ-035 rst asserted at step 3 -> outputs 0 immediately, before next clk edge; after release, start with no loads streams all zeros with out_valid high for 7 cycles.
REQ-036 start held high continuously for 20 cycles -> back-to-back streams, each 7 valid cycles followed by one done cycle; no start accepted during STREAM/DONE.
